memory_3_to_1_arbiter: RTL and testbench

//  Round-robin scheduler sharing the 3-port-to-single-port memory wrapper between three requesters.

---
 rtl/memory_3_to_1_arbiter_pkg.sv | 36 +++
 rtl/memory_3_to_1_arbiter_rr_arbiter_3.sv | 50 +++++
 rtl/memory_3_to_1_arbiter.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_memory_3_to_1_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_3_to_1_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// memory_3_to_1_arbiter_pkg
//   Shared definitions for the three-requester memory arbiter:
//   port count, port-id width, control FSM encoding, round-robin pointer
//   reset value and small port-id helpers.
//   No ports (package).
// ----------------------------------------------------------------------------
package memory_3_to_1_arbiter_pkg;

    localparam int NUM_PORTS = 3;
    localparam int PORT_W    = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HELD  = 2'd2
    } arb_state_t;

    // Pointer starts on the last port so the first search begins at port 0.
    localparam logic [PORT_W-1:0] RR_PTR_RST = 2'd2;

    // Next port in round-robin order, wrapping 2 -> 0.
    function automatic logic [PORT_W-1:0] port_after(input logic [PORT_W-1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Encode a one-hot (or all-zero) port vector; all-zero yields port 0.
    function automatic logic [PORT_W-1:0] onehot_to_id(input logic [NUM_PORTS-1:0] oh);
        logic [PORT_W-1:0] id;
        id = 2'd0;
        if (oh[1]) id = 2'd1;
        if (oh[2]) id = 2'd2;
        return id;
    endfunction

endpackage

// File: rtl/memory_3_to_1_arbiter_rr_arbiter_3.sv
// ----------------------------------------------------------------------------
// rr_arbiter_3
//   Pure combinational round-robin pick among three requesters.
//   Search order starting after the pointer p: p+1, p+2, p (mod 3).
// Ports
//   req_i     in  3   request vector
//   rr_ptr_i  in  2   last granted port
//   gnt_o     out 3   one-hot grant (zero when no request)
//   gnt_id_o  out 2   encoded id of the granted port
//   gnt_any_o out 1   a grant was made
// ----------------------------------------------------------------------------
module rr_arbiter_3
    import memory_3_to_1_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    rr_ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [PORT_W-1:0]    gnt_id_o,
    output logic                 gnt_any_o
);

    logic [PORT_W-1:0] first_p;
    logic [PORT_W-1:0] second_p;
    logic [PORT_W-1:0] third_p;

    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_any_o = 1'b0;
        first_p   = port_after(rr_ptr_i);
        second_p  = port_after(first_p);
        third_p   = rr_ptr_i;

        if (req_i[first_p]) begin
            gnt_id_o  = first_p;
            gnt_any_o = 1'b1;
        end else if (req_i[second_p]) begin
            gnt_id_o  = second_p;
            gnt_any_o = 1'b1;
        end else if (req_i[third_p]) begin
            gnt_id_o  = third_p;
            gnt_any_o = 1'b1;
        end

        if (gnt_any_o) begin
            gnt_o[gnt_id_o] = 1'b1;
        end
    end

endmodule

// File: rtl/memory_3_to_1_arbiter.sv
// ----------------------------------------------------------------------------
// memory_3_to_1_arbiter
//   Round-robin scheduler sharing the 3-port-to-single-port memory wrapper
//   between three requesters. At most one access is granted per cycle; the
//   grant is registered onto the wrapper's mem_k_* strobes the next cycle and
//   read returns are tagged with the requesting port. A hold/drain FSM lets
//   the controller quiesce memory traffic before a phase change.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_k/we_k/addr_k/din_k  requester k command (held until gnt_k)
//   gnt_k                    combinational grant; transfer on req_k & gnt_k
//   rd_valid_k               rd_data belongs to port k this cycle
//   rd_data                  mem_dout passthrough
//   hold / idle              quiesce request / quiesced indication
//   addr_err                 sticky: an out-of-range address was granted
//   mem_k_*                  registered strobes/addr/data to the wrapper
//   mem_dout                 read data from the wrapper
// ----------------------------------------------------------------------------
module memory_3_to_1_arbiter
    import memory_3_to_1_arbiter_pkg::*;
#(
    parameter int WIDTH                = 64,
    parameter int SINGLE_MEM_DEPTH     = 7,
    parameter int SINGLE_MEM_DEPTH_LOG = $clog2(SINGLE_MEM_DEPTH),
    parameter int RD_LATENCY           = 1
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            req_0,
    input  logic                            we_0,
    input  logic [SINGLE_MEM_DEPTH_LOG-1:0] addr_0,
    input  logic [WIDTH-1:0]                din_0,
    input  logic                            req_1,
    input  logic                            we_1,
    input  logic [SINGLE_MEM_DEPTH_LOG-1:0] addr_1,
    input  logic [WIDTH-1:0]                din_1,
    input  logic                            req_2,
    input  logic                            we_2,
    input  logic [SINGLE_MEM_DEPTH_LOG-1:0] addr_2,
    input  logic [WIDTH-1:0]                din_2,

    output logic                            gnt_0,
    output logic                            gnt_1,
    output logic                            gnt_2,
    output logic                            rd_valid_0,
    output logic                            rd_valid_1,
    output logic                            rd_valid_2,
    output logic [WIDTH-1:0]                rd_data,

    input  logic                            hold,
    output logic                            idle,
    output logic                            addr_err,

    output logic                            mem_0_wr_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_0_wr_addr,
    output logic [WIDTH-1:0]                mem_0_din,
    output logic                            mem_0_rd_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_0_rd_addr,
    output logic                            mem_1_wr_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_1_wr_addr,
    output logic [WIDTH-1:0]                mem_1_din,
    output logic                            mem_1_rd_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_1_rd_addr,
    output logic                            mem_2_wr_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_2_wr_addr,
    output logic [WIDTH-1:0]                mem_2_din,
    output logic                            mem_2_rd_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_2_rd_addr,

    input  logic [WIDTH-1:0]                mem_dout
);

    localparam int AW = SINGLE_MEM_DEPTH_LOG;
    // One extra bit so a power-of-two depth is still representable.
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(SINGLE_MEM_DEPTH);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    arb_state_t        state_q, state_d;
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic              addr_err_q, addr_err_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] arb_gnt;
    logic [PORT_W-1:0]    arb_id;
    logic                 arb_any;
    logic                 arb_en;
    logic                 grant_fire;
    logic [NUM_PORTS-1:0] gnt_vec;

    logic                 sel_we;
    logic [AW-1:0]        sel_addr;
    logic [WIDTH-1:0]     sel_din;
    logic                 addr_ok;

    assign req_vec = {req_2, req_1, req_0};

    rr_arbiter_3 u_rr (
        .req_i     (req_vec),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_id_o  (arb_id),
        .gnt_any_o (arb_any)
    );

    // Grants only in RUN with hold low; a request arriving with hold's rise
    // is therefore never granted. rst gating keeps gnt low during reset.
    assign arb_en     = (state_q == ST_RUN) && !hold && !rst;
    assign grant_fire = arb_en && arb_any;
    assign gnt_vec    = arb_en ? arb_gnt : '0;

    assign gnt_0 = gnt_vec[0];
    assign gnt_1 = gnt_vec[1];
    assign gnt_2 = gnt_vec[2];

    always_comb begin
        sel_we   = we_0;
        sel_addr = addr_0;
        sel_din  = din_0;
        case (arb_id)
            2'd1: begin
                sel_we   = we_1;
                sel_addr = addr_1;
                sel_din  = din_1;
            end
            2'd2: begin
                sel_we   = we_2;
                sel_addr = addr_2;
                sel_din  = din_2;
            end
            default: ;
        endcase
    end

    // Out-of-range addresses would alias into the neighbouring sub-memory
    // inside the wrapper, so they complete the handshake but never issue.
    assign addr_ok = ({1'b0, sel_addr} < DEPTH_LIM);

    // ------------------------------------------------------------------
    // Issue stage: per-port registered strobes; every field is zero on
    // ports not issuing so the wrapper mux sees at most one strobe.
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] wr_en_q, wr_en_d;
    logic [NUM_PORTS-1:0] rd_en_q, rd_en_d;
    logic [AW-1:0]        wr_addr_q [NUM_PORTS];
    logic [AW-1:0]        wr_addr_d [NUM_PORTS];
    logic [AW-1:0]        rd_addr_q [NUM_PORTS];
    logic [AW-1:0]        rd_addr_d [NUM_PORTS];
    logic [WIDTH-1:0]     din_q     [NUM_PORTS];
    logic [WIDTH-1:0]     din_d     [NUM_PORTS];

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            wr_en_d[k]   = gnt_vec[k] & addr_ok & sel_we;
            rd_en_d[k]   = gnt_vec[k] & addr_ok & ~sel_we;
            wr_addr_d[k] = wr_en_d[k] ? sel_addr : '0;
            rd_addr_d[k] = rd_en_d[k] ? sel_addr : '0;
            din_d[k]     = wr_en_d[k] ? sel_din  : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q <= '0;
            rd_en_q <= '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                wr_addr_q[k] <= '0;
                rd_addr_q[k] <= '0;
                din_q[k]     <= '0;
            end
        end else begin
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            for (int k = 0; k < NUM_PORTS; k++) begin
                wr_addr_q[k] <= wr_addr_d[k];
                rd_addr_q[k] <= rd_addr_d[k];
                din_q[k]     <= din_d[k];
            end
        end
    end

    assign mem_0_wr_en   = wr_en_q[0];
    assign mem_0_wr_addr = wr_addr_q[0];
    assign mem_0_din     = din_q[0];
    assign mem_0_rd_en   = rd_en_q[0];
    assign mem_0_rd_addr = rd_addr_q[0];
    assign mem_1_wr_en   = wr_en_q[1];
    assign mem_1_wr_addr = wr_addr_q[1];
    assign mem_1_din     = din_q[1];
    assign mem_1_rd_en   = rd_en_q[1];
    assign mem_1_rd_addr = rd_addr_q[1];
    assign mem_2_wr_en   = wr_en_q[2];
    assign mem_2_wr_addr = wr_addr_q[2];
    assign mem_2_din     = din_q[2];
    assign mem_2_rd_en   = rd_en_q[2];
    assign mem_2_rd_addr = rd_addr_q[2];

    // ------------------------------------------------------------------
    // Read tag pipe: follows the issue stage by RD_LATENCY cycles so the
    // last stage lines up with mem_dout.
    // ------------------------------------------------------------------
    logic [RD_LATENCY-1:0] tag_vld_q;
    logic [PORT_W-1:0]     tag_port_q [RD_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q[0] <= |rd_en_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_port_q[0] <= onehot_to_id(rd_en_q);
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_port_q[i] <= tag_port_q[i-1];
        end
    end

    assign rd_valid_0 = tag_vld_q[RD_LATENCY-1] && (tag_port_q[RD_LATENCY-1] == 2'd0);
    assign rd_valid_1 = tag_vld_q[RD_LATENCY-1] && (tag_port_q[RD_LATENCY-1] == 2'd1);
    assign rd_valid_2 = tag_vld_q[RD_LATENCY-1] && (tag_port_q[RD_LATENCY-1] == 2'd2);
    assign rd_data    = mem_dout;

    // ------------------------------------------------------------------
    // Drain detection: the final tag stage is being returned this cycle,
    // so it does not keep DRAIN alive. This puts HELD one cycle after the
    // last rd_valid.
    // ------------------------------------------------------------------
    logic drained;

    always_comb begin
        drained = ~(|wr_en_q) & ~(|rd_en_q);
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
            if (tag_vld_q[i]) drained = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            rr_ptr_q   <= RR_PTR_RST;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        addr_err_d = addr_err_q;

        if (grant_fire) begin
            rr_ptr_d = arb_id;
            if (!addr_ok) addr_err_d = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (hold) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!hold)        state_d = ST_RUN;
                else if (drained) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (!hold) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Nothing can be in flight while reset is held, so idle reads high then.
    assign idle     = rst || (state_q == ST_HELD);
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_memory_3_to_1_arbiter.sv
// ----------------------------------------------------------------------------
// tb_memory_3_to_1_arbiter
//   Directed bench for memory_3_to_1_arbiter with a small behavioural model
//   of the 3-to-1 memory wrapper (one registered read port, RD_LATENCY=1).
// ----------------------------------------------------------------------------
module tb_memory_3_to_1_arbiter;

    localparam int W  = 64;
    localparam int D  = 7;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_0, req_1, req_2;
    logic          we_0, we_1, we_2;
    logic [AW-1:0] addr_0, addr_1, addr_2;
    logic [W-1:0]  din_0, din_1, din_2;
    logic          hold;
    logic [W-1:0]  mem_dout;

    logic          gnt_0, gnt_1, gnt_2;
    logic          rd_valid_0, rd_valid_1, rd_valid_2;
    logic [W-1:0]  rd_data;
    logic          idle, addr_err;
    logic          mem_0_wr_en, mem_1_wr_en, mem_2_wr_en;
    logic          mem_0_rd_en, mem_1_rd_en, mem_2_rd_en;
    logic [AW-1:0] mem_0_wr_addr, mem_1_wr_addr, mem_2_wr_addr;
    logic [AW-1:0] mem_0_rd_addr, mem_1_rd_addr, mem_2_rd_addr;
    logic [W-1:0]  mem_0_din, mem_1_din, mem_2_din;

    memory_3_to_1_arbiter #(
        .WIDTH(W), .SINGLE_MEM_DEPTH(D), .SINGLE_MEM_DEPTH_LOG(AW), .RD_LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .din_0(din_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .din_1(din_1),
        .req_2(req_2), .we_2(we_2), .addr_2(addr_2), .din_2(din_2),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2),
        .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1), .rd_valid_2(rd_valid_2),
        .rd_data(rd_data), .hold(hold), .idle(idle), .addr_err(addr_err),
        .mem_0_wr_en(mem_0_wr_en), .mem_0_wr_addr(mem_0_wr_addr), .mem_0_din(mem_0_din),
        .mem_0_rd_en(mem_0_rd_en), .mem_0_rd_addr(mem_0_rd_addr),
        .mem_1_wr_en(mem_1_wr_en), .mem_1_wr_addr(mem_1_wr_addr), .mem_1_din(mem_1_din),
        .mem_1_rd_en(mem_1_rd_en), .mem_1_rd_addr(mem_1_rd_addr),
        .mem_2_wr_en(mem_2_wr_en), .mem_2_wr_addr(mem_2_wr_addr), .mem_2_din(mem_2_din),
        .mem_2_rd_en(mem_2_rd_en), .mem_2_rd_addr(mem_2_rd_addr),
        .mem_dout(mem_dout)
    );

    logic [2:0] gnt_v, rd_v, wr_v, vld_v;
    assign gnt_v = {gnt_2, gnt_1, gnt_0};
    assign rd_v  = {mem_2_rd_en, mem_1_rd_en, mem_0_rd_en};
    assign wr_v  = {mem_2_wr_en, mem_1_wr_en, mem_0_wr_en};
    assign vld_v = {rd_valid_2, rd_valid_1, rd_valid_0};

    // Wrapper model: sub-memory k word a preloads to A5A5_0000_0000_kkaa.
    logic [W-1:0] mem_m [3][8];

    function automatic logic [W-1:0] init_word(input logic [7:0] k, input logic [7:0] a);
        return {16'hA5A5, 32'h0, k, a};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++)
                for (int a = 0; a < 8; a++)
                    mem_m[k][a] <= init_word(8'(k), 8'(a));
            mem_dout <= '0;
        end else begin
            if (mem_0_wr_en) mem_m[0][mem_0_wr_addr] <= mem_0_din;
            if (mem_1_wr_en) mem_m[1][mem_1_wr_addr] <= mem_1_din;
            if (mem_2_wr_en) mem_m[2][mem_2_wr_addr] <= mem_2_din;
            if (mem_0_rd_en)      mem_dout <= mem_m[0][mem_0_rd_addr];
            else if (mem_1_rd_en) mem_dout <= mem_m[1][mem_1_rd_addr];
            else if (mem_2_rd_en) mem_dout <= mem_m[2][mem_2_rd_addr];
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [63:0] exp_cont [3];

    initial begin
        exp_cont[0] = 64'hA5A5_0000_0000_0000;
        exp_cont[1] = 64'hA5A5_0000_0000_0101;
        exp_cont[2] = 64'hA5A5_0000_0000_0202;

        rst = 1'b1; hold = 1'b0;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 3'd0; din_0 = '0;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 3'd1; din_1 = '0;
        req_2 = 1'b1; we_2 = 1'b0; addr_2 = 3'd2; din_2 = '0;

        // Reset state with all requests already held
        repeat (2) cyc();
        #1;
        chk("rst_gnt",   gnt_v, 0);
        chk("rst_idle",  idle, 1);
        chk("rst_aerr",  addr_err, 0);
        chk("rst_rd",    rd_v, 0);
        chk("rst_wr",    wr_v, 0);
        chk("rst_vld",   vld_v, 0);

        // Full contention: grants 0,1,2,0,1,2,... strobes follow one cycle later
        cyc(); rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) cyc();
            #1;
            chk("cont_gnt", gnt_v, 64'(1 << (i % 3)));
            chk("cont_rd",  rd_v, (i >= 1) ? 64'(1 << ((i - 1) % 3)) : 64'd0);
            chk("cont_wr",  wr_v, 0);
            chk("cont_vld", vld_v, (i >= 2) ? 64'(1 << ((i - 2) % 3)) : 64'd0);
            if (i >= 2) chk("cont_data", rd_data, exp_cont[(i - 2) % 3]);
            if (i == 0) chk("run_idle", idle, 0);
        end
        cyc(); req_0 = 1'b0; req_1 = 1'b0; req_2 = 1'b0;
        #1; chk("cont_stop", gnt_v, 0);
        repeat (2) cyc();

        // Single read: port 1, addr 3
        cyc(); req_1 = 1'b1; addr_1 = 3'd3; we_1 = 1'b0;
        #1; chk("rd1_gnt", gnt_v, 3'b010);
        cyc(); req_1 = 1'b0;
        #1; chk("rd1_strobe", rd_v, 3'b010);
        chk("rd1_addr", mem_1_rd_addr, 3);
        chk("rd1_wr", wr_v, 0);
        cyc(); #1;
        chk("rd1_vld", vld_v, 3'b010);
        chk("rd1_data", rd_data, 64'hA5A5_0000_0000_0103);
        cyc(); #1;
        chk("rd1_vld_off", vld_v, 0);

        // Write then read back on port 2, addr 6
        cyc(); req_2 = 1'b1; we_2 = 1'b1; addr_2 = 3'd6; din_2 = 64'h0000_0000_DEAD_BEEF;
        #1; chk("wr2_gnt", gnt_v, 3'b100);
        cyc(); we_2 = 1'b0;
        #1; chk("rd2_gnt", gnt_v, 3'b100);
        chk("wr2_strobe", wr_v, 3'b100);
        chk("wr2_addr", mem_2_wr_addr, 6);
        chk("wr2_din", mem_2_din, 64'h0000_0000_DEAD_BEEF);
        chk("wr2_rd_off", rd_v, 0);
        cyc(); req_2 = 1'b0;
        #1; chk("rd2_strobe", rd_v, 3'b100);
        chk("rd2_addr", mem_2_rd_addr, 6);
        cyc(); #1;
        chk("rd2_vld", vld_v, 3'b100);
        chk("rd2_data", rd_data, 64'h0000_0000_DEAD_BEEF);

        // Neighbours at addr 6 untouched
        cyc(); req_0 = 1'b1; addr_0 = 3'd6; req_1 = 1'b1; addr_1 = 3'd6;
        #1; chk("nb_gnt0", gnt_v, 3'b001);
        cyc(); req_0 = 1'b0;
        #1; chk("nb_gnt1", gnt_v, 3'b010);
        cyc(); req_1 = 1'b0;
        #1; chk("nb_vld0", vld_v, 3'b001);
        chk("nb_data0", rd_data, 64'hA5A5_0000_0000_0006);
        cyc(); #1;
        chk("nb_vld1", vld_v, 3'b010);
        chk("nb_data1", rd_data, 64'hA5A5_0000_0000_0106);

        // Hold with two reads outstanding
        cyc(); req_0 = 1'b1; addr_0 = 3'd1; req_2 = 1'b1; addr_2 = 3'd5;
        #1; chk("hd_gnt2", gnt_v, 3'b100);
        cyc(); req_2 = 1'b0;
        #1; chk("hd_gnt0", gnt_v, 3'b001);
        cyc(); req_0 = 1'b0; hold = 1'b1; req_1 = 1'b1; addr_1 = 3'd2;
        #1; chk("hd_block", gnt_v, 0);
        chk("hd_vld2", vld_v, 3'b100);
        chk("hd_data2", rd_data, 64'hA5A5_0000_0000_0205);
        chk("hd_idle_a", idle, 0);
        cyc(); #1;
        chk("hd_block2", gnt_v, 0);
        chk("hd_vld0", vld_v, 3'b001);
        chk("hd_data0", rd_data, 64'hA5A5_0000_0000_0001);
        chk("hd_idle_b", idle, 0);
        cyc(); #1;
        chk("hd_idle_c", idle, 1);
        chk("hd_block3", gnt_v, 0);
        chk("hd_rd_quiet", rd_v, 0);
        cyc(); #1;
        chk("hd_idle_d", idle, 1);
        cyc(); hold = 1'b0;
        #1; chk("hd_rel_gnt", gnt_v, 0);
        chk("hd_rel_idle", idle, 1);
        cyc(); #1;
        chk("hd_resume", gnt_v, 3'b010);
        chk("hd_run_idle", idle, 0);
        cyc(); req_1 = 1'b0;
        #1; chk("hd_rd1", rd_v, 3'b010);
        chk("hd_rd1_addr", mem_1_rd_addr, 2);
        cyc(); #1;
        chk("hd_vld1", vld_v, 3'b010);
        chk("hd_data1", rd_data, 64'hA5A5_0000_0000_0102);

        // Address error: port 0, addr 7
        cyc(); req_0 = 1'b1; addr_0 = 3'd7;
        #1; chk("ae_gnt", gnt_v, 3'b001);
        chk("ae_pre", addr_err, 0);
        cyc(); req_0 = 1'b0;
        #1; chk("ae_rd", rd_v, 0);
        chk("ae_wr", wr_v, 0);
        chk("ae_set", addr_err, 1);
        cyc(); #1;
        chk("ae_vld", vld_v, 0);
        repeat (3) cyc();
        #1; chk("ae_sticky", addr_err, 1);

        // Reset in the middle of a read
        cyc(); req_0 = 1'b1; addr_0 = 3'd4;
        #1; chk("mr_gnt", gnt_v, 3'b001);
        cyc(); req_0 = 1'b1; req_1 = 1'b1; req_2 = 1'b1;
        addr_1 = 3'd1; addr_2 = 3'd2;
        #1; chk("mr_issue", rd_v, 3'b001);
        rst = 1'b1;
        #1;
        chk("mr_rd", rd_v, 0);
        chk("mr_gnt_rst", gnt_v, 0);
        chk("mr_idle", idle, 1);
        chk("mr_aerr", addr_err, 0);
        chk("mr_vld", vld_v, 0);
        cyc(); #1;
        chk("mr_no_vld", vld_v, 0);
        cyc(); rst = 1'b0;
        #1; chk("mr_ptr", gnt_v, 3'b001);
        chk("mr_run_idle", idle, 0);
        cyc(); req_0 = 1'b0; req_1 = 1'b0; req_2 = 1'b0;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
